serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial adder sequencer. Time-multiplexes one 1-bit full adder over
//  WIDTH cycles (LSB first) to add two WIDTH-bit operands plus carry-in.
//  Trades latency for area. Sits beside the ripple adders as the low-area
//  add unit, with a start/ready/done handshake to its requester.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 2..64
//  CNT_W   $clog2(WIDTH)   bit-counter width (derived, not overridden)
// PORTS
//  clk     in   1      single clock, rising edge
//  rst_n   in   1      asynchronous, active-low reset
//  start   in   1      request; accepted only when ready=1
//  a       in   WIDTH  operand A, sampled on the accepting edge
//  b       in   WIDTH  operand B, sampled on the accepting edge
//  cin     in   1      carry-in, sampled on the accepting edge
//  ready   out  1      1 only in IDLE
//  busy    out  1      1 in RUN
//  done    out  1      one-cycle pulse, result valid
//  sum     out  WIDTH  result, held until next completion
//  cout    out  1      carry out of the MSB
//  ovf     out  1      signed overflow = carry into MSB XOR cout
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, ready=1, busy=0, done=0, sum=0,
//   cout=0, ovf=0, counter=0, shift/carry regs=0. Effective immediately.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: ready=1. On an edge with start=1: latch a, b into shift regs,
//   cin into carry reg, counter=0, go RUN. start=0: stay IDLE.
//  RUN: busy=1, ready=0. Each edge: FA inputs = opA[0], opB[0], carry.
//   FA sum shifts into the result shift reg at MSB (shift right).
//   FA carry -> carry reg. opA/opB shift right. counter++.
//   On the edge where counter==WIDTH-1, go DONE and write: sum <= the
//   full shifted result, cout <= FA carry, ovf <= carry_reg XOR FA carry
//   (carry_reg then holds the carry into the MSB).
//  DONE: done=1 for exactly one cycle; ready=0, busy=0. Next edge -> IDLE.
//  Latency: start accepted at edge E0; RUN spans edges E1..EW; done=1 in
//   the cycle after EW. Start-accept to done = WIDTH+1 cycles.
//   Issue interval = WIDTH+2 cycles.
//  start while RUN/DONE: ignored, not queued. Operand changes after
//   accept: no effect.
//  sum/cout/ovf change only on the DONE-entry edge (and reset); stable
//   during RUN.
//  Arithmetic: {cout,sum} = a + b + cin modulo 2^(WIDTH+1), unsigned.
//  Reset mid-RUN: operation aborted, outputs zeroed, no done pulse;
//   next start after release behaves as from power-up.
//  Counter never exceeds WIDTH-1. Illegal state encodings -> IDLE.
// STRUCTURE
//  Shared package: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1,
//   ST_DONE=2'd2) as localparams; default WIDTH constant.
//  One sub-module: fullAdder_1bit, the existing one-bit full adder,
//   instantiated once for the datapath. Controller FSM, counter and
//   shift registers live in this module.
// TESTING
//  1. a=8'h0F, b=8'h01, cin=0 -> done 9 cycles after accept; sum=8'h10,
//     cout=0, ovf=0.
//  2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0;
//     a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//  3. a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, ovf=1;
//     a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
//  4. start pulsed every cycle with changing operands during RUN ->
//     ignored; result matches first operands; ready=0 until IDLE.
//  5. rst_n low at RUN cycle 4 -> all outputs 0 immediately, no done;
//     a fresh start afterwards -> correct result.
//  6. 2000 random a/b/cin, back-to-back at max rate -> every done matches
//     a+b+cin; exactly one done per accept; sum stable between dones.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
// State codes and the default operand width.
package serial_adder_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full adder, reused as the serial datapath
// of the low-area add unit.
module fullAdder_1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic p;

  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder stepped LSB first
// over WIDTH cycles, with start/ready/done handshake.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_sh;

  fullAdder_1bit u_fa (
    .a_i (opa_q[0]),
    .b_i (opb_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_co)
  );

  assign res_sh = {fa_s, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        res_d   = res_sh;
        carry_d = fa_co;
        if (cnt_q == CNT_LAST) begin
          // carry_q is the carry into the MSB here
          sum_d   = res_sh;
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl against
// an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int W  = 8;
  localparam int W1 = W + 1;
  localparam int N  = 2000;

  typedef struct {
    logic [W:0] r;
    logic       ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         ready, busy, done, cout, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  function automatic logic [W:0] ref_add(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         c
  );
    return {1'b0, x} + {1'b0, y} + W1'(c);
  endfunction

  // signed overflow: equal operand signs, differing result sign
  function automatic logic ref_ovf(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         c
  );
    logic [W:0] r;
    r = ref_add(x, y, c);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // drives one request and waits for its done pulse
  task automatic run_op(
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         c,
    output logic [W-1:0] s,
    output logic         co,
    output logic         ov,
    output int           lat,
    output bit           ok
  );
    int n;
    ok  = 1'b0;
    lat = 0;
    s   = '0;
    co  = 1'b0;
    ov  = 1'b0;
    n   = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) return;
    a = x;
    b = y;
    cin = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    for (lat = 1; lat <= 50; lat++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    s  = sum;
    co = cout;
    ov = ovf;
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got r%b b%b d%b want r1 b0 d0",
               ready, busy, done);
    end
    checks++;
    if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_res got %h/%b/%b want 00/0/0",
               sum, cout, ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] tx [5] = '{8'h0F, 8'hFF, 8'hFF, 8'h7F, 8'h80};
    logic [W-1:0] ty [5] = '{8'h01, 8'h01, 8'hFF, 8'h01, 8'h80};
    logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] es [5] = '{8'h10, 8'h00, 8'hFF, 8'h80, 8'h00};
    logic         ec [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] s;
    logic         co, ov;
    int           lat;
    bit           ok;
    for (int i = 0; i < 5; i++) begin
      run_op(tx[i], ty[i], tc[i], s, co, ov, lat, ok);
      checks++;
      if (!ok || lat != W + 1) begin
        errors++;
        $display("FAIL dir%0d_latency got %0d ok=%0b want %0d",
                 i, lat, ok, W + 1);
      end
      checks++;
      if (s !== es[i] || co !== ec[i] || ov !== eo[i]) begin
        errors++;
        $display("FAIL dir%0d_result got %h/%b/%b want %h/%b/%b",
                 i, s, co, ov, es[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [W:0] er;
    logic       eov;
    int         n;
    int         bad_ready;
    int         extra;
    er  = ref_add(8'h3C, 8'h5A, 1'b1);
    eov = ref_ovf(8'h3C, 8'h5A, 1'b1);
    @(negedge clk);
    a = 8'h3C;
    b = 8'h5A;
    cin = 1'b1;
    start = 1'b1;
    @(posedge clk);
    bad_ready = 0;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
      if (ready !== 1'b0) bad_ready++;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
    end
    checks++;
    if (done !== 1'b1 || n != W + 1) begin
      errors++;
      $display("FAIL ign_latency got %0d want %0d", n, W + 1);
    end
    checks++;
    if (bad_ready != 0) begin
      errors++;
      $display("FAIL ign_ready got %0d ready-high cycles want 0",
               bad_ready);
    end
    checks++;
    if ({cout, sum} !== er || ovf !== eov) begin
      errors++;
      $display("FAIL ign_result got %b%h/%b want %h/%b",
               cout, sum, ovf, er, eov);
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ign_back_idle got ready=%b want 1", ready);
    end
    start = 1'b0;
    extra = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ign_queued got %0d active cycles want 0",
               extra);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] s;
    logic         co, ov;
    logic [W-1:0] x, y;
    logic         c;
    int           lat;
    bit           ok;
    int           dn;
    run_op(8'h21, 8'h13, 1'b0, s, co, ov, lat, ok);
    checks++;
    if (!ok || s !== 8'h34) begin
      errors++;
      $display("FAIL rst_pre got %h ok=%0b want 34", s, ok);
    end
    @(negedge clk);
    a = 8'hAA;
    b = 8'h55;
    cin = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got r%b b%b d%b %h/%b/%b want 1 0 0 00/0/0",
               ready, busy, done, sum, cout, ovf);
    end
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL rst_no_done got %0d pulses want 0", dn);
    end
    x = W'($urandom);
    y = W'($urandom);
    c = 1'($urandom);
    run_op(x, y, c, s, co, ov, lat, ok);
    checks++;
    if (!ok || {co, s} !== ref_add(x, y, c) ||
        ov !== ref_ovf(x, y, c) || lat != W + 1) begin
      errors++;
      $display("FAIL rst_after got %b%h/%b lat %0d want %h/%b lat %0d",
               co, s, ov, lat, ref_add(x, y, c), ref_ovf(x, y, c),
               W + 1);
    end
  endtask

  task automatic test_back_to_back();
    exp_t         q[$];
    exp_t         e;
    logic [W-1:0] x, y;
    logic         c;
    logic [W-1:0] ps;
    logic         pc, po;
    int           nacc, ndone, cyc, last_acc;
    int           budget;
    nacc = 0;
    ndone = 0;
    cyc = 0;
    last_acc = 0;
    budget = N * (W + 2) + 200;
    @(negedge clk);
    ps = sum;
    pc = cout;
    po = ovf;
    while (ndone < N && cyc < budget) begin
      if (cyc != 0) @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_done at cycle %0d got pulse want none",
                   cyc);
        end else begin
          e = q.pop_front();
          if ({cout, sum} !== e.r || ovf !== e.ov) begin
            errors++;
            $display("FAIL b2b_result #%0d got %b%h/%b want %h/%b",
                     ndone, cout, sum, ovf, e.r, e.ov);
          end
        end
        ndone++;
      end else begin
        checks++;
        if (sum !== ps || cout !== pc || ovf !== po) begin
          errors++;
          $display("FAIL b2b_stable got %h/%b/%b want %h/%b/%b",
                   sum, cout, ovf, ps, pc, po);
        end
      end
      ps = sum;
      pc = cout;
      po = ovf;
      if (ready === 1'b1 && nacc < N) begin
        if (nacc > 0) begin
          checks++;
          if (cyc - last_acc != W + 2) begin
            errors++;
            $display("FAIL b2b_interval got %0d want %0d",
                     cyc - last_acc, W + 2);
          end
        end
        last_acc = cyc;
        x = W'($urandom);
        y = W'($urandom);
        c = 1'($urandom);
        a = x;
        b = y;
        cin = c;
        start = 1'b1;
        e.r  = ref_add(x, y, c);
        e.ov = ref_ovf(x, y, c);
        q.push_back(e);
        nacc++;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != N || nacc != N || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got %0d done %0d acc %0d left want %0d",
               ndone, nacc, q.size(), N);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
